// File: rtl/id_fwd_scoreboard.sv
// ID-stage operand forwarding and load-use hazard scoreboard.
// Tracks the last FWD_STAGES issued instructions and picks the youngest producer per operand.
module id_fwd_scoreboard #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned LOAD_LAT   = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pipe_stall,
  input  logic                           flush,
  input  logic                           iss_valid,
  input  logic [REG_ADDR_W-1:0]          iss_ra_addr,
  input  logic [REG_ADDR_W-1:0]          iss_rb_addr,
  input  logic                           iss_ra_used,
  input  logic                           iss_rb_used,
  input  logic [REG_ADDR_W-1:0]          iss_dst_addr,
  input  logic                           iss_gpr_we,
  input  logic                           iss_is_load,
  input  logic [DATA_W-1:0]              gpr_rd_data_0,
  input  logic [DATA_W-1:0]              gpr_rd_data_1,
  input  logic [FWD_STAGES*DATA_W-1:0]   fwd_data,
  output logic [DATA_W-1:0]              ra_data,
  output logic [DATA_W-1:0]              rb_data,
  output logic                           iss_stall,
  output logic                           iss_fire,
  output logic [CNT_W-1:0]               stall_cnt
);

  localparam int NStg    = int'(FWD_STAGES);
  localparam int LoadIdx = int'(LOAD_LAT) - 1;

  logic [FWD_STAGES-1:0]                 valid_q, valid_d;
  logic [FWD_STAGES-1:0]                 we_q, we_d;
  logic [FWD_STAGES-1:0]                 load_q, load_d;
  logic [FWD_STAGES-1:0][REG_ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]                      stall_cnt_q, stall_cnt_d;

  logic [FWD_STAGES-1:0] slot_avail;
  logic [FWD_STAGES-1:0] ra_match, rb_match;
  logic                  ra_found, rb_found;
  logic                  ra_avail, rb_avail;
  logic                  ra_hazard, rb_hazard;

  // A load only becomes forwardable once it has reached slot LOAD_LAT-1.
  always_comb begin
    slot_avail = '0;
    ra_match   = '0;
    rb_match   = '0;
    for (int k = 0; k < NStg; k++) begin
      slot_avail[k] = ~load_q[k] | (k >= LoadIdx);
      ra_match[k]   = valid_q[k] & we_q[k] & (dst_q[k] == iss_ra_addr);
      rb_match[k]   = valid_q[k] & we_q[k] & (dst_q[k] == iss_rb_addr);
    end
  end

  // Scan oldest to youngest so the lowest matching slot ends up selected.
  always_comb begin
    ra_data  = gpr_rd_data_0;
    ra_found = 1'b0;
    ra_avail = 1'b1;
    rb_data  = gpr_rd_data_1;
    rb_found = 1'b0;
    rb_avail = 1'b1;
    for (int k = NStg - 1; k >= 0; k--) begin
      if (ra_match[k]) begin
        ra_data  = fwd_data[k*DATA_W +: DATA_W];
        ra_found = 1'b1;
        ra_avail = slot_avail[k];
      end
      if (rb_match[k]) begin
        rb_data  = fwd_data[k*DATA_W +: DATA_W];
        rb_found = 1'b1;
        rb_avail = slot_avail[k];
      end
    end
  end

  always_comb begin
    ra_hazard = iss_valid & iss_ra_used & ra_found & ~ra_avail;
    rb_hazard = iss_valid & iss_rb_used & rb_found & ~rb_avail;
    iss_stall = ra_hazard | rb_hazard;
    iss_fire  = iss_valid & ~iss_stall & ~pipe_stall & ~flush;
    stall_cnt = stall_cnt_q;
  end

  always_comb begin
    valid_d     = valid_q;
    we_d        = we_q;
    load_d      = load_q;
    dst_d       = dst_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      valid_d = '0;
    end else if (!pipe_stall) begin
      for (int k = 1; k < NStg; k++) begin
        valid_d[k] = valid_q[k-1];
        we_d[k]    = we_q[k-1];
        load_d[k]  = load_q[k-1];
        dst_d[k]   = dst_q[k-1];
      end
      // A non-firing cycle enters as a bubble; only the valid bit matters then.
      valid_d[0] = iss_fire;
      we_d[0]    = iss_gpr_we;
      load_d[0]  = iss_is_load;
      dst_d[0]   = iss_dst_addr;
    end

    if (iss_valid && iss_stall && !pipe_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      we_q        <= '0;
      load_q      <= '0;
      dst_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      we_q        <= we_d;
      load_q      <= load_d;
      dst_q       <= dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
